// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: owns the single register-file write port and shares it
// between the WB stage (top priority, no backpressure) and a long-latency
// auxiliary unit that enters through a small valid/ready FIFO.
// A pending bitmap exposes buffered destinations to the hazard unit. A
// one-cycle WB bubble request (stall_wb) is raised when aux writes starve.
// Optional feature macro: RF_ARB_BYPASS_EN. When defined, an aux request
// that arrives with an empty FIFO and an idle WB slot is issued directly.
module rf_write_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 4,
  parameter int REG_COUNT     = 15,
  parameter int FIFO_DEPTH    = 4,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_req_en,
  input  logic [ADDRESS_WIDTH-1:0] wb_req_dest,
  input  logic [DATA_WIDTH-1:0]    wb_req_value,
  input  logic                     aux_valid,
  output logic                     aux_ready,
  input  logic [ADDRESS_WIDTH-1:0] aux_dest,
  input  logic [DATA_WIDTH-1:0]    aux_value,
  output logic                     WB_en,
  output logic [ADDRESS_WIDTH-1:0] WB_Dest,
  output logic [DATA_WIDTH-1:0]    WB_Value,
  output logic [REG_COUNT-1:0]     pending,
  output logic                     stall_wb,
  output logic                     proto_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]       FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDRESS_WIDTH:0] REG_LIMIT  = (ADDRESS_WIDTH + 1)'(REG_COUNT);
  localparam logic [STV_W-1:0]       STARVE_MAX = STV_W'(STARVE_LIMIT);

  // FIFO storage and bookkeeping
  logic [ADDRESS_WIDTH-1:0] fifo_dest_q  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    fifo_value_q [FIFO_DEPTH];
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [FIFO_DEPTH-1:0]    entry_valid;

  // Output port registers
  logic                     wb_en_q, wb_en_d;
  logic [ADDRESS_WIDTH-1:0] wb_dest_q, wb_dest_d;
  logic [DATA_WIDTH-1:0]    wb_value_q, wb_value_d;

  // Starvation and protocol tracking
  logic [STV_W-1:0]         starve_q, starve_d;
  logic                     stall_q, stall_d;
  logic                     stall_seen_q;
  logic                     proto_q, proto_d;

  // Per-cycle decisions
  logic                     fifo_empty;
  logic                     push;
  logic                     pop;
  logic                     bypass;
  logic                     iss_valid;
  logic [ADDRESS_WIDTH-1:0] iss_dest;
  logic [DATA_WIDTH-1:0]    iss_value;
  logic                     iss_dest_ok;
  logic [REG_COUNT-1:0]     wb_dest_hot;
  logic                     wb_hazard;

  assign fifo_empty = (count_q == '0);
  // Ready depends only on registered occupancy; held low during reset.
  assign aux_ready  = !rst && (count_q != FULL_COUNT);
  // WB always wins the slot; the FIFO head only drains in idle WB cycles.
  assign pop        = !wb_req_en && !fifo_empty;

`ifdef RF_ARB_BYPASS_EN
  assign bypass = !wb_req_en && fifo_empty && aux_valid && aux_ready;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed request is issued directly and never occupies an entry.
  assign push = aux_valid && aux_ready && !bypass;

  // Entry i is live when it lies within count slots of the read pointer.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      logic [PTR_W-1:0] offset;
      assign offset          = PTR_W'(gi) - rd_ptr_q;
      assign entry_valid[gi] = ({1'b0, offset} < count_q);
    end
  endgenerate

  // Pending bit r is the OR of all live entries targeting r; duplicates
  // keep the bit set until the last of them drains.
  generate
    for (genvar gr = 0; gr < REG_COUNT; gr++) begin : g_reg
      logic [FIFO_DEPTH-1:0] match;
      for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_match
        assign match[gi] = entry_valid[gi] && (fifo_dest_q[gi] == ADDRESS_WIDTH'(gr));
      end
      assign pending[gr]     = |match;
      assign wb_dest_hot[gr] = (wb_req_dest == ADDRESS_WIDTH'(gr));
    end
  endgenerate

  assign wb_hazard = wb_req_en && |(pending & wb_dest_hot);

  // Select the request that owns the write port this cycle.
  always_comb begin
    iss_valid = 1'b0;
    iss_dest  = wb_req_dest;
    iss_value = wb_req_value;
    if (wb_req_en) begin
      iss_valid = 1'b1;
    end else if (pop) begin
      iss_valid = 1'b1;
      iss_dest  = fifo_dest_q[rd_ptr_q];
      iss_value = fifo_value_q[rd_ptr_q];
    end else if (bypass) begin
      iss_valid = 1'b1;
      iss_dest  = aux_dest;
      iss_value = aux_value;
    end
  end

  // Out-of-range destinations are consumed silently; data holds when idle.
  always_comb begin
    iss_dest_ok = ({1'b0, iss_dest} < REG_LIMIT);
    wb_en_d     = iss_valid && iss_dest_ok;
    wb_dest_d   = wb_dest_q;
    wb_value_d  = wb_value_q;
    if (wb_en_d) begin
      wb_dest_d  = iss_dest;
      wb_value_d = iss_value;
    end
  end

  // FIFO pointer and occupancy update.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Starvation counter, one-shot bubble request and sticky protocol flag.
  always_comb begin
    starve_d = '0;
    stall_d  = 1'b0;
    if (!fifo_empty && wb_req_en) begin
      if (starve_q + STV_W'(1) == STARVE_MAX) begin
        stall_d = 1'b1;
      end else begin
        starve_d = starve_q + STV_W'(1);
      end
    end
    // Violations: WB presented right after a bubble request, or WB
    // overtaking a buffered write to the same register.
    proto_d = proto_q || (stall_seen_q && wb_req_en) || wb_hazard;
  end

  // Control and output state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      wb_en_q      <= 1'b0;
      wb_dest_q    <= '0;
      wb_value_q   <= '0;
      starve_q     <= '0;
      stall_q      <= 1'b0;
      stall_seen_q <= 1'b0;
      proto_q      <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      wb_en_q      <= wb_en_d;
      wb_dest_q    <= wb_dest_d;
      wb_value_q   <= wb_value_d;
      starve_q     <= starve_d;
      stall_q      <= stall_d;
      stall_seen_q <= stall_q;
      proto_q      <= proto_d;
    end
  end

  // FIFO payload storage; validity is tracked by pointers and count only.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dest_q[wr_ptr_q]  <= aux_dest;
      fifo_value_q[wr_ptr_q] <= aux_value;
    end
  end

  assign WB_en     = wb_en_q;
  assign WB_Dest   = wb_dest_q;
  assign WB_Value  = wb_value_q;
  assign stall_wb  = stall_q;
  assign proto_err = proto_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter. A small model tracks the aux
// FIFO contents and the expected register-file write stream; each scenario
// task drives cycles and compares DUT outputs inline against the model.
module tb_rf_write_arbiter;

  typedef struct packed {
    logic [3:0]  d;
    logic [31:0] v;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        wb_req_en;
  logic [3:0]  wb_req_dest;
  logic [31:0] wb_req_value;
  logic        aux_valid;
  logic        aux_ready;
  logic [3:0]  aux_dest;
  logic [31:0] aux_value;
  logic        WB_en;
  logic [3:0]  WB_Dest;
  logic [31:0] WB_Value;
  logic [14:0] pending;
  logic        stall_wb;
  logic        proto_err;

  wr_t  mq[$];     // model of the aux FIFO
  wr_t  exp_q[$];  // expected register-file writes in issue order
  logic exp_en;
  wr_t  want;
  int   checks = 0;
  int   errors = 0;

  rf_write_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .wb_req_en   (wb_req_en),
    .wb_req_dest (wb_req_dest),
    .wb_req_value(wb_req_value),
    .aux_valid   (aux_valid),
    .aux_ready   (aux_ready),
    .aux_dest    (aux_dest),
    .aux_value   (aux_value),
    .WB_en       (WB_en),
    .WB_Dest     (WB_Dest),
    .WB_Value    (WB_Value),
    .pending     (pending),
    .stall_wb    (stall_wb),
    .proto_err   (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] calc_pending();
    logic [14:0] p;
    p = '0;
    foreach (mq[i]) begin
      if (mq[i].d < 4'd15) p[mq[i].d] = 1'b1;
    end
    return p;
  endfunction

  // Drive one cycle of stimulus, advance the model, and step the clock.
  task automatic drive_cycle(input logic wen, input logic [3:0] wd, input logic [31:0] wv,
                             input logic av, input logic [3:0] ad, input logic [31:0] avv);
    wr_t  it;
    logic acc;
    logic byp;
    logic iss;
    wb_req_en    = wen;
    wb_req_dest  = wd;
    wb_req_value = wv;
    aux_valid    = av;
    aux_dest     = ad;
    aux_value    = avv;
    it  = '0;
    acc = av && (mq.size() < 4);
    byp = 1'b0;
`ifdef RF_ARB_BYPASS_EN
    byp = acc && !wen && (mq.size() == 0);
`endif
    iss = 1'b0;
    if (wen) begin
      iss = 1'b1;
      it  = '{d: wd, v: wv};
    end else if (mq.size() > 0) begin
      iss = 1'b1;
      it  = mq.pop_front();
    end else if (byp) begin
      iss = 1'b1;
      it  = '{d: ad, v: avv};
    end
    exp_en = iss && (it.d < 4'd15);
    if (exp_en) exp_q.push_back(it);
    if (acc && !byp) mq.push_back('{d: ad, v: avv});
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wb_req_en = 1'b0; aux_valid = 1'b0;
    wb_req_dest = '0; wb_req_value = '0; aux_dest = '0; aux_value = '0;
    tick();
    tick();
    rst = 1'b0;
    mq.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wb_req_en = 1'b0; wb_req_dest = '0; wb_req_value = '0;
    aux_valid = 1'b1; aux_dest = 4'd2; aux_value = 32'h5;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({WB_en, WB_Dest, WB_Value, pending, stall_wb, proto_err, aux_ready} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got en=%b dest=%0d val=%h pend=%h stall=%b perr=%b rdy=%b want all 0",
                 k, WB_en, WB_Dest, WB_Value, pending, stall_wb, proto_err, aux_ready);
      end
    end
    rst = 1'b0;
    aux_valid = 1'b0;
    mq.delete();
    exp_q.delete();
    #1;
    checks++;
    if (aux_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", aux_ready);
    end
    drive_cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (WB_en !== 1'b0 || pending !== 15'h0 || aux_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_empty got en=%b pend=%h rdy=%b want 0/0/1", WB_en, pending, aux_ready);
    end
  endtask

  task automatic test_wb_path();
    drive_cycle(1, 4'd3, 32'hDEADBEEF, 0, 0, 0);
    checks++;
    if (WB_en !== exp_en || exp_en !== 1'b1) begin
      errors++;
      $display("FAIL wb_path_en got %b want 1", WB_en);
    end else begin
      want = exp_q.pop_front();
      checks++;
      if (WB_Dest !== want.d || WB_Value !== want.v) begin
        errors++;
        $display("FAIL wb_path_write got %0d/%h want %0d/%h", WB_Dest, WB_Value, want.d, want.v);
      end else $display("wr dest=%0d val=%h", WB_Dest, WB_Value);
    end
    drive_cycle(0, 4'd8, 32'h0, 0, 0, 0);
    checks++;
    if (WB_en !== 1'b0 || WB_Dest !== 4'd3 || WB_Value !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wb_path_idle got en=%b dest=%0d val=%h want 0/3/deadbeef", WB_en, WB_Dest, WB_Value);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  d;
    logic [31:0] v;
    for (int k = 0; k < 6; k++) begin
      d = 4'($urandom_range(0, 14));
      v = $urandom;
      drive_cycle(1, d, v, 0, 0, 0);
      checks++;
      if (WB_en !== exp_en) begin
        errors++;
        $display("FAIL b2b_en got %b want %b", WB_en, exp_en);
      end else if (exp_en) begin
        want = exp_q.pop_front();
        checks++;
        if (WB_Dest !== want.d || WB_Value !== want.v) begin
          errors++;
          $display("FAIL b2b_write got %0d/%h want %0d/%h", WB_Dest, WB_Value, want.d, want.v);
        end else $display("wr dest=%0d val=%h", WB_Dest, WB_Value);
      end
    end
    drive_cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (WB_en !== 1'b0) begin
      errors++;
      $display("FAIL b2b_tail got %b want 0", WB_en);
    end
  endtask

  task automatic test_aux_buffer();
    logic [3:0] dests [4];
    dests = '{4'd1, 4'd2, 4'd1, 4'd5};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1, 4'd9, 32'h1000 + i, 1, dests[i], 32'hA0 + i);
      checks++;
      if (WB_en !== exp_en) begin
        errors++;
        $display("FAIL auxbuf_fill_en got %b want %b", WB_en, exp_en);
      end else if (exp_en) begin
        want = exp_q.pop_front();
        checks++;
        if (WB_Dest !== want.d || WB_Value !== want.v) begin
          errors++;
          $display("FAIL auxbuf_fill_write got %0d/%h want %0d/%h", WB_Dest, WB_Value, want.d, want.v);
        end else $display("wr dest=%0d val=%h", WB_Dest, WB_Value);
      end
    end
    checks++;
    if (aux_ready !== 1'b0 || pending !== 15'b000000000100110) begin
      errors++;
      $display("FAIL auxbuf_full got rdy=%b pend=%b want 0/000000000100110", aux_ready, pending);
    end
    for (int k = 0; k < 6; k++) begin
      drive_cycle(0, 0, 0, 0, 0, 0);
      checks++;
      if (WB_en !== exp_en) begin
        errors++;
        $display("FAIL auxbuf_drain_en cyc=%0d got %b want %b", k, WB_en, exp_en);
      end else if (exp_en) begin
        want = exp_q.pop_front();
        checks++;
        if (WB_Dest !== want.d || WB_Value !== want.v) begin
          errors++;
          $display("FAIL auxbuf_drain_write got %0d/%h want %0d/%h", WB_Dest, WB_Value, want.d, want.v);
        end else $display("wr dest=%0d val=%h", WB_Dest, WB_Value);
      end
      checks++;
      if (pending !== calc_pending()) begin
        errors++;
        $display("FAIL auxbuf_pending cyc=%0d got %b want %b", k, pending, calc_pending());
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL auxbuf_leftover got %0d writes missing want 0", exp_q.size());
    end
  endtask

  task automatic test_aux_path();
    do_reset();
    drive_cycle(0, 0, 0, 1, 4'd7, 32'h12);
    checks++;
    if (WB_en !== exp_en) begin
      errors++;
      $display("FAIL auxpath_first_en got %b want %b", WB_en, exp_en);
    end else if (exp_en) begin
      want = exp_q.pop_front();
      checks++;
      if (WB_Dest !== want.d || WB_Value !== want.v) begin
        errors++;
        $display("FAIL auxpath_first_write got %0d/%h want %0d/%h", WB_Dest, WB_Value, want.d, want.v);
      end else $display("wr dest=%0d val=%h", WB_Dest, WB_Value);
    end
    checks++;
    if (pending !== calc_pending()) begin
      errors++;
      $display("FAIL auxpath_pending got %b want %b", pending, calc_pending());
    end
    for (int k = 0; k < 2; k++) begin
      drive_cycle(0, 0, 0, 0, 0, 0);
      checks++;
      if (WB_en !== exp_en) begin
        errors++;
        $display("FAIL auxpath_en cyc=%0d got %b want %b", k, WB_en, exp_en);
      end else if (exp_en) begin
        want = exp_q.pop_front();
        checks++;
        if (WB_Dest !== want.d || WB_Value !== want.v) begin
          errors++;
          $display("FAIL auxpath_write got %0d/%h want %0d/%h", WB_Dest, WB_Value, want.d, want.v);
        end else $display("wr dest=%0d val=%h", WB_Dest, WB_Value);
      end
    end
    checks++;
    if (exp_q.size() != 0 || pending !== 15'h0) begin
      errors++;
      $display("FAIL auxpath_done got left=%0d pend=%h want 0/0", exp_q.size(), pending);
    end
  endtask

  task automatic test_invalid_dest();
    do_reset();
    drive_cycle(1, 4'd9, 32'h11, 1, 4'd15, 32'hBAD);
    checks++;
    if (WB_en !== exp_en || pending !== 15'h0) begin
      errors++;
      $display("FAIL inval_push got en=%b pend=%h want %b/0", WB_en, pending, exp_en);
    end else if (exp_en) begin
      want = exp_q.pop_front();
      checks++;
      if (WB_Dest !== want.d || WB_Value !== want.v) begin
        errors++;
        $display("FAIL inval_push_write got %0d/%h want %0d/%h", WB_Dest, WB_Value, want.d, want.v);
      end else $display("wr dest=%0d val=%h", WB_Dest, WB_Value);
    end
    drive_cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (WB_en !== 1'b0) begin
      errors++;
      $display("FAIL inval_pop_en got %b want 0", WB_en);
    end
    drive_cycle(1, 4'd15, 32'h22, 0, 0, 0);
    checks++;
    if (WB_en !== 1'b0) begin
      errors++;
      $display("FAIL inval_wb_en got %b want 0", WB_en);
    end
    drive_cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (proto_err !== 1'b0 || WB_en !== 1'b0 || aux_ready !== 1'b1) begin
      errors++;
      $display("FAIL inval_state got perr=%b en=%b rdy=%b want 0/0/1", proto_err, WB_en, aux_ready);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1, 4'd10, 32'h200 + i, 1, 4'(i + 1), 32'h300 + i);
      checks++;
      if (WB_en !== exp_en) begin
        errors++;
        $display("FAIL fullpop_fill_en got %b want %b", WB_en, exp_en);
      end else if (exp_en) begin
        want = exp_q.pop_front();
        checks++;
        if (WB_Dest !== want.d || WB_Value !== want.v) begin
          errors++;
          $display("FAIL fullpop_fill_write got %0d/%h want %0d/%h", WB_Dest, WB_Value, want.d, want.v);
        end else $display("wr dest=%0d val=%h", WB_Dest, WB_Value);
      end
    end
    checks++;
    if (aux_ready !== 1'b0) begin
      errors++;
      $display("FAIL fullpop_ready got %b want 0", aux_ready);
    end
    drive_cycle(0, 0, 0, 1, 4'd7, 32'h77);
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (WB_en !== exp_en) begin
        errors++;
        $display("FAIL fullpop_drain_en cyc=%0d got %b want %b", k, WB_en, exp_en);
      end else if (exp_en) begin
        want = exp_q.pop_front();
        checks++;
        if (WB_Dest !== want.d || WB_Value !== want.v) begin
          errors++;
          $display("FAIL fullpop_drain_write got %0d/%h want %0d/%h", WB_Dest, WB_Value, want.d, want.v);
        end else $display("wr dest=%0d val=%h", WB_Dest, WB_Value);
      end
      drive_cycle(0, 0, 0, 0, 0, 0);
    end
    checks++;
    if (exp_q.size() != 0 || pending !== 15'h0 || WB_en !== 1'b0) begin
      errors++;
      $display("FAIL fullpop_done got left=%0d pend=%h en=%b want 0/0/0", exp_q.size(), pending, WB_en);
    end
  endtask

  task automatic test_hazard();
    do_reset();
    drive_cycle(1, 4'd9, 32'h1, 1, 4'd6, 32'h66);
    drive_cycle(1, 4'd6, 32'h55, 0, 0, 0);
    checks++;
    if (proto_err !== 1'b1) begin
      errors++;
      $display("FAIL hazard_perr got %b want 1", proto_err);
    end
    for (int k = 0; k < 3; k++) begin
      drive_cycle(0, 0, 0, 0, 0, 0);
    end
    // Replay order check: the stream is 9/1, 6/55, 6/66 from the model.
    checks++;
    if (exp_q.size() != 3) begin
      errors++;
      $display("FAIL hazard_model got %0d queued want 3", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_hazard_order();
    do_reset();
    drive_cycle(1, 4'd9, 32'h1, 1, 4'd6, 32'h66);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (WB_en !== exp_en) begin
        errors++;
        $display("FAIL hzord_en cyc=%0d got %b want %b", k, WB_en, exp_en);
      end else if (exp_en) begin
        want = exp_q.pop_front();
        checks++;
        if (WB_Dest !== want.d || WB_Value !== want.v) begin
          errors++;
          $display("FAIL hzord_write got %0d/%h want %0d/%h", WB_Dest, WB_Value, want.d, want.v);
        end else $display("wr dest=%0d val=%h", WB_Dest, WB_Value);
      end
      if (k == 0) drive_cycle(1, 4'd6, 32'h55, 0, 0, 0);
      else drive_cycle(0, 0, 0, 0, 0, 0);
    end
    checks++;
    if (proto_err !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL hzord_done got perr=%b left=%0d want 1/0", proto_err, exp_q.size());
    end
  endtask

  task automatic test_starvation(input logic violate);
    do_reset();
    drive_cycle(1, 4'd9, 32'h0, 1, 4'd4, 32'h44);
    for (int k = 1; k <= 8; k++) begin
      drive_cycle(1, 4'd9, 32'(k), 0, 0, 0);
      checks++;
      if (stall_wb !== (k == 8)) begin
        errors++;
        $display("FAIL starve_stall cyc=%0d got %b want %b", k, stall_wb, (k == 8));
      end
    end
    drive_cycle(1, 4'd9, 32'd100, 0, 0, 0);
    checks++;
    if (stall_wb !== 1'b0 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL starve_pulse got stall=%b perr=%b want 0/0", stall_wb, proto_err);
    end
    exp_q.delete();
    if (violate) drive_cycle(1, 4'd9, 32'd200, 0, 0, 0);
    else drive_cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (WB_en !== exp_en) begin
      errors++;
      $display("FAIL starve_after_en got %b want %b", WB_en, exp_en);
    end else if (exp_en) begin
      want = exp_q.pop_front();
      checks++;
      if (WB_Dest !== want.d || WB_Value !== want.v) begin
        errors++;
        $display("FAIL starve_after_write got %0d/%h want %0d/%h", WB_Dest, WB_Value, want.d, want.v);
      end else $display("wr dest=%0d val=%h", WB_Dest, WB_Value);
    end
    checks++;
    if (proto_err !== violate) begin
      errors++;
      $display("FAIL starve_perr got %b want %b", proto_err, violate);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    drive_cycle(1, 4'd9, 32'h1, 1, 4'd3, 32'h33);
    drive_cycle(1, 4'd9, 32'h2, 1, 4'd4, 32'h34);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive_cycle(0, 0, 0, 0, 0, 0);
      checks++;
      if (WB_en !== 1'b0 || pending !== 15'h0 || proto_err !== 1'b0) begin
        errors++;
        $display("FAIL midreset cyc=%0d got en=%b pend=%h perr=%b want 0/0/0", k, WB_en, pending, proto_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wb_path();
    test_back_to_back();
    test_aux_buffer();
    test_aux_path();
    test_invalid_dest();
    test_full_pop();
    test_hazard();
    test_hazard_order();
    test_starvation(1'b0);
    test_starvation(1'b1);
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Owns the single register-file write port (WB_en / WB_Dest / WB_Value) and shares it between two requesters:
  - the pipeline WB stage, which has top priority and no backpressure;
  - a long-latency auxiliary unit (multiplier, multi-register load), which uses a valid/ready handshake into a small FIFO.
- Tracks which registers have buffered writes pending, so the hazard unit can stall dependent reads.
- Forces a WB bubble when aux writes starve.
- Sits between the WB stage / aux unit and the register file. The register file writes on negedge; this block is posedge.

Parameters:
- DATA_WIDTH, 32, write data width
- ADDRESS_WIDTH, 4, register index width
- REG_COUNT, 15, number of writable registers; dest >= REG_COUNT is invalid
- FIFO_DEPTH, 4, aux write buffer entries (power of two, >= 2)
- STARVE_LIMIT, 8, consecutive aux-starved cycles before a WB bubble is forced

Ports:
- clk, input, 1, clock, rising edge
- rst, input, 1, synchronous active-high reset
- wb_req_en, input, 1, WB stage write request
- wb_req_dest, input, ADDRESS_WIDTH, WB destination register
- wb_req_value, input, DATA_WIDTH, WB write data
- aux_valid, input, 1, aux unit write request
- aux_ready, output, 1, FIFO can accept an aux request
- aux_dest, input, ADDRESS_WIDTH, aux destination register
- aux_value, input, DATA_WIDTH, aux write data
- WB_en, output, 1, register-file write enable
- WB_Dest, output, ADDRESS_WIDTH, register-file write index
- WB_Value, output, DATA_WIDTH, register-file write data
- pending, output, REG_COUNT, bit r set while the FIFO holds a write to register r
- stall_wb, output, 1, pipeline must not present wb_req_en next cycle
- proto_err, output, 1, sticky protocol-violation flag

Behaviour:
- Reset (rst=1 at a rising edge):
  - WB_en=0, WB_Dest=0, WB_Value=0, pending=0, stall_wb=0, proto_err=0.
  - FIFO emptied; read/write pointers, count and starve counter cleared.
  - aux_ready=0 while rst is high and 1 the cycle after.
  - A reset mid-operation discards all buffered writes; no partial write is emitted.
- Handshake:
  - aux_ready = (count != FIFO_DEPTH), taken from registered count only.
  - Push when aux_valid && aux_ready.
  - When full, no push is accepted even if a pop occurs the same cycle.
  - aux_dest/aux_value must stay stable while aux_valid=1 && aux_ready=0.
- Selection, evaluated every cycle t:
  1. If wb_req_en=1: issue the WB request.
  2. Else if count>0: pop the FIFO head and issue it.
  3. Else: issue nothing.
- Output timing and latency:
  - The issued request is registered onto WB_en/WB_Dest/WB_Value at edge t+1.
  - When nothing is issued, WB_en=0 and WB_Dest/WB_Value hold their previous values.
  - WB latency: 1 cycle.
  - Aux latency (FIFO path): push at t, earliest pop at t+1, WB_en at t+2.
- Invalid destinations:
  - A request with dest >= REG_COUNT is consumed (popped or ignored) but produces WB_en=0 that cycle.
  - A consumed invalid request does not set proto_err.
- Pending bitmap:
  - pending[r] = OR over valid FIFO entries of (dest==r).
  - Recomputed from registered FIFO state every cycle.
  - Covers duplicate entries to the same register.
- Starvation:
  - The starve counter increments each cycle that count>0 and wb_req_en=1; otherwise it clears.
  - When it reaches STARVE_LIMIT: stall_wb=1 for exactly one cycle, and the counter clears.
  - In the cycle after stall_wb, the pipeline guarantees wb_req_en=0, so the FIFO head issues.
  - If wb_req_en=1 in that cycle anyway, WB still wins and proto_err sets (sticky until rst).
- FIFO pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- Simultaneous push and pop in one cycle leaves count unchanged; entry order is strictly FIFO.
- Write ordering: the hazard unit must not let WB target a register whose pending bit is set. If WB writes register r while pending[r]=1, proto_err sets and both writes still occur in issue order.

Optional Feature:
- Macro: RF_ARB_BYPASS_EN.
- Defined: when count==0, wb_req_en=0 and aux_valid=1 at cycle t, the aux request is accepted and issued directly without enqueue. WB_en rises at t+1, and pending is never set for that write.
- Not defined: every accepted aux request passes through the FIFO, with a minimum 2-cycle latency.

Test Plan:
- Reset behaviour: rst=1 for 2 cycles with aux_valid=1 -> all outputs 0 and aux_ready=0; cycle after release, aux_ready=1 and FIFO is empty.
- WB path: wb_req_en=1, dest=3, value=0xDEADBEEF at t -> WB_en=1, WB_Dest=3, WB_Value=0xDEADBEEF at t+1; WB_en=0 at t+2.
- Aux buffering (bypass off): 4 aux pushes to dests 1,2,1,5 while wb_req_en=1 -> aux_ready=0 after the 4th push and pending=0b000000000100110. When wb_req_en drops, writes emerge in order 1,2,1,5 on consecutive cycles; pending[1] clears only after the second dest-1 write.
- Starvation: FIFO holds 1 entry and wb_req_en held at 1 -> stall_wb pulses after 8 cycles. With wb_req_en=0 the following cycle, the aux entry writes; with wb_req_en=1 instead, proto_err=1.
- Invalid destination: aux push with dest=15 -> popped with WB_en=0 and proto_err stays 0. Back-to-back push and pop at count=4 -> no push accepted that cycle.
- Bypass on: count=0, aux_valid=1, dest=7, value=0x12 at t -> WB_en=1, WB_Dest=7 at t+1, and pending stays 0.
